ahb2apb_bridge_nslv: RTL and testbench
======================================

AHB2APB_BRIDGE_NSLV -- requirements
Module: ahb2apb_bridge_nslv

Interface
REQ-001 Parameters SHALL be, one per line:
- ADDR_WIDTH, 32, AHB/APB address width.
- DATA_WIDTH, 32, data bus width.
- NUM_SLAVES, 16, number of PSEL lines, 1..16.
- SLOT_BITS, 8, low address bits per slave slot; slot index = HADDR[SLOT_BITS +: 4].
- TIMEOUT_CYCLES, 256, ACCESS-phase wait limit, 2..65535.
REQ-002 Ports SHALL be, one per line:
- HCLK in 1: the single clock.
- HRESET in 1: reset, synchronous and active-high.
- HSEL in 1: bridge select.
- HTRANS in 2: AHB transfer type.
- HWRITE in 1: write when high.
- HADDR in ADDR_WIDTH: AHB address.
- HWDATA in DATA_WIDTH: AHB write data.
- HREADYIN in 1: bus ready.
- HREADYOUT out 1: bridge ready.
- HRDATA out DATA_WIDTH: read data.
- HRESP out 1: 1 = ERROR.
- PSEL out NUM_SLAVES: one-hot APB select.
- PADDR out ADDR_WIDTH: APB address.
- PWRITE out 1: APB write.
- PENABLE out 1: APB enable.
- PWDATA out DATA_WIDTH: APB write data.
- PRDATA in DATA_WIDTH: APB read data.
- PREADY in 1: APB ready.
- PSLVERR in 1: APB slave error.
REQ-003 All state SHALL be clocked on HCLK rising edge; every output SHALL be registered.

Function
REQ-010 States SHALL be IDLE, LATCH, SETUP, ACCESS, ERR1, ERR2.
REQ-011 Capture: when in IDLE or ERR2, the bridge SHALL capture HADDR/HWRITE if HSEL & HREADYIN & HTRANS[1].
- On capture, it SHALL go to LATCH.
- If slot index >= NUM_SLAVES, it SHALL go to ERR1 instead, with no APB activity.
REQ-012 HTRANS IDLE/BUSY with HSEL SHALL receive a zero-wait OKAY with no APB activity.
REQ-013 LATCH SHALL register HWDATA into PWDATA on writes only; PWDATA SHALL hold otherwise. Next state is SETUP.
REQ-014 SETUP SHALL drive:
- PSEL[slot] = 1, PENABLE = 0.
- PADDR and PWRITE from captured values.
- Next state ACCESS.
REQ-015 ACCESS SHALL hold PENABLE = 1 and all APB outputs stable until PREADY = 1.
REQ-016 ACCESS completion, on PREADY = 1 & PSLVERR = 0:
- Reads SHALL register PRDATA into HRDATA.
- PSEL and PENABLE SHALL go 0.
- Next state IDLE.
REQ-017 ACCESS completion, on PREADY = 1 & PSLVERR = 1: PSEL and PENABLE SHALL go 0, next state ERR1; HRDATA SHALL be unchanged.
REQ-018 HREADYOUT SHALL be 0 in LATCH, SETUP, ACCESS and ERR1, and 1 in IDLE and ERR2.
REQ-019 HRESP SHALL be 1 in ERR1 and ERR2, and 0 otherwise. ERR1 SHALL always go to ERR2.
REQ-020 Latency with zero APB wait SHALL be 4 HCLK from address phase to HREADYOUT = 1. Each PREADY-low cycle SHALL add 1 cycle.
REQ-021 PSEL SHALL be one-hot or zero at all times. PENABLE = 1 SHALL only occur in the cycle after SETUP or while waiting in ACCESS.

Reset
REQ-030 With HRESET = 1 at a clock edge, the outputs SHALL take these values next cycle:
- state IDLE, PSEL 0, PENABLE 0, PWRITE 0, PADDR 0, PWDATA 0.
- HRDATA 0, HREADYOUT 1, HRESP 0.
- timeout counter 0.
REQ-031 Reset asserted mid-transfer, in any state, SHALL abort immediately with no completion response; no capture SHALL occur while HRESET = 1.

Configuration
REQ-040 Macro AHB2APB_TIMEOUT_EN defined:
- A 16-bit counter SHALL clear on entering ACCESS and increment each ACCESS cycle with PREADY = 0.
- When the count reaches TIMEOUT_CYCLES with PREADY still 0, the bridge SHALL drop PSEL and PENABLE and go to ERR1.
REQ-041 Macro AHB2APB_TIMEOUT_EN undefined: the counter SHALL be absent and ACCESS SHALL wait for PREADY indefinitely.

Verification
REQ-050 Write 0xA5A5_0001 to 0x0000_0304, PREADY = 1 -> PSEL = 0x0008, PADDR = 0x304, PWDATA = 0xA5A50001, PENABLE high 1 cycle, HREADYOUT = 1 four cycles after the address phase, HRESP = 0.
REQ-051 Read 0x0000_0010 with PREADY low 3 cycles and PRDATA = 0x1234_5678 -> PSEL = 0x0001, HRDATA = 0x12345678, total latency 7 cycles.
REQ-052 Read with PSLVERR = 1 -> two-cycle ERROR: HRESP = 1 for 2 cycles, HREADYOUT = 0 then 1; a NONSEQ issued in ERR2 is captured.
REQ-053 With NUM_SLAVES = 4, access 0x0000_0500 -> PSEL stays 0, two-cycle ERROR.
REQ-054 AHB2APB_TIMEOUT_EN with TIMEOUT_CYCLES = 8 and PREADY held 0 -> PSEL and PENABLE drop after 8 ACCESS cycles, then ERROR; without the macro, the bridge stays in ACCESS.
REQ-055 HRESET pulsed during ACCESS -> next cycle all outputs at reset values; a following write completes normally.

Source files
------------

// File: rtl/ahb2apb_bridge_nslv.sv
// ahb2apb_bridge_nslv: AHB-Lite slave to APB bridge with slot-decoded one-hot PSEL.
// Optional ACCESS-phase timeout is built when AHB2APB_TIMEOUT_EN is defined.
module ahb2apb_bridge_nslv #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_SLAVES     = 16,
   parameter int SLOT_BITS      = 8,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  HSEL,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic [DATA_WIDTH-1:0] HWDATA,
   input  logic                  HREADYIN,
   output logic                  HREADYOUT,
   output logic [DATA_WIDTH-1:0] HRDATA,
   output logic                  HRESP,
   output logic [NUM_SLAVES-1:0] PSEL,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic                  PWRITE,
   output logic                  PENABLE,
   output logic [DATA_WIDTH-1:0] PWDATA,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LATCH  = 3'd1,
      ST_SETUP  = 3'd2,
      ST_ACCESS = 3'd3,
      ST_ERR1   = 3'd4,
      ST_ERR2   = 3'd5
   } state_t;

   localparam logic [4:0]            LP_NSLV     = 5'(NUM_SLAVES);
   localparam logic [NUM_SLAVES-1:0] LP_PSEL_ONE = NUM_SLAVES'(1'b1);

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_write;
   logic [3:0]            r_slot;
   logic                  r_hreadyout;
   logic                  r_hresp;
   logic [DATA_WIDTH-1:0] r_hrdata;
   logic [NUM_SLAVES-1:0] r_psel;
   logic [ADDR_WIDTH-1:0] r_paddr;
   logic                  r_pwrite;
   logic                  r_penable;
   logic [DATA_WIDTH-1:0] r_pwdata;

   logic [3:0] w_slot;
   logic       w_capture;
   logic       w_slot_ok;
   logic       w_unused;

   assign w_slot    = HADDR[SLOT_BITS +: 4];
   assign w_capture = HSEL & HREADYIN & HTRANS[1];
   assign w_slot_ok = ({1'b0, w_slot} < LP_NSLV);

`ifdef AHB2APB_TIMEOUT_EN
   localparam logic [15:0] LP_TO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] r_cnt;
   assign w_unused = HTRANS[0];
`else
   assign w_unused = ^{HTRANS[0], 16'(TIMEOUT_CYCLES)};
`endif

   // Bridge sequencer: every AHB and APB output is a register updated on state transitions
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_state     <= ST_IDLE;
         r_addr      <= {ADDR_WIDTH{1'b0}};
         r_write     <= 1'b0;
         r_slot      <= 4'd0;
         r_hreadyout <= 1'b1;
         r_hresp     <= 1'b0;
         r_hrdata    <= {DATA_WIDTH{1'b0}};
         r_psel      <= {NUM_SLAVES{1'b0}};
         r_paddr     <= {ADDR_WIDTH{1'b0}};
         r_pwrite    <= 1'b0;
         r_penable   <= 1'b0;
         r_pwdata    <= {DATA_WIDTH{1'b0}};
`ifdef AHB2APB_TIMEOUT_EN
         r_cnt       <= 16'd0;
`endif
      end else begin
         case (r_state)
            ST_IDLE, ST_ERR2: begin
               if (w_capture) begin
                  r_addr      <= HADDR;
                  r_write     <= HWRITE;
                  r_slot      <= w_slot;
                  r_hreadyout <= 1'b0;
                  // An unmapped slot skips the APB phases and answers ERROR directly
                  if (w_slot_ok) begin
                     r_state <= ST_LATCH;
                     r_hresp <= 1'b0;
                  end else begin
                     r_state <= ST_ERR1;
                     r_hresp <= 1'b1;
                  end
               end else begin
                  r_state     <= ST_IDLE;
                  r_hreadyout <= 1'b1;
                  r_hresp     <= 1'b0;
               end
            end
            ST_LATCH: begin
               if (r_write) begin
                  r_pwdata <= HWDATA;
               end
               r_psel   <= LP_PSEL_ONE << r_slot;
               r_paddr  <= r_addr;
               r_pwrite <= r_write;
               r_state  <= ST_SETUP;
            end
            ST_SETUP: begin
               r_penable <= 1'b1;
               r_state   <= ST_ACCESS;
`ifdef AHB2APB_TIMEOUT_EN
               r_cnt     <= 16'd0;
`endif
            end
            ST_ACCESS: begin
               if (PREADY) begin
                  r_psel    <= {NUM_SLAVES{1'b0}};
                  r_penable <= 1'b0;
                  if (PSLVERR) begin
                     r_state <= ST_ERR1;
                     r_hresp <= 1'b1;
                  end else begin
                     if (!r_write) begin
                        r_hrdata <= PRDATA;
                     end
                     r_state     <= ST_IDLE;
                     r_hreadyout <= 1'b1;
                  end
               end
`ifdef AHB2APB_TIMEOUT_EN
               else if (r_cnt == LP_TO_LAST) begin
                  r_psel    <= {NUM_SLAVES{1'b0}};
                  r_penable <= 1'b0;
                  r_state   <= ST_ERR1;
                  r_hresp   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
`endif
            end
            ST_ERR1: begin
               r_state     <= ST_ERR2;
               r_hreadyout <= 1'b1;
               r_hresp     <= 1'b1;
            end
            default: begin
               r_state     <= ST_IDLE;
               r_psel      <= {NUM_SLAVES{1'b0}};
               r_penable   <= 1'b0;
               r_hreadyout <= 1'b1;
               r_hresp     <= 1'b0;
            end
         endcase
      end
   end

   assign HREADYOUT = r_hreadyout;
   assign HRDATA    = r_hrdata;
   assign HRESP     = r_hresp;
   assign PSEL      = r_psel;
   assign PADDR     = r_paddr;
   assign PWRITE    = r_pwrite;
   assign PENABLE   = r_penable;
   assign PWDATA    = r_pwdata;

endmodule

// File: tb/tb_ahb2apb_bridge_nslv.sv
// Self-checking bench for ahb2apb_bridge_nslv: directed and random AHB transfers against a
// transaction-level model of latency, APB selection, data and error response.
module tb_ahb2apb_bridge_nslv;

   localparam int NS = 4;
   localparam int TO = 8;

   logic          HCLK = 1'b0;
   logic          HRESET;
   logic          HSEL;
   logic [1:0]    HTRANS;
   logic          HWRITE;
   logic [31:0]   HADDR;
   logic [31:0]   HWDATA;
   logic          HREADYIN;
   logic          HREADYOUT;
   logic [31:0]   HRDATA;
   logic          HRESP;
   logic [NS-1:0] PSEL;
   logic [31:0]   PADDR;
   logic          PWRITE;
   logic          PENABLE;
   logic [31:0]   PWDATA;
   logic [31:0]   PRDATA;
   logic          PREADY;
   logic          PSLVERR;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] model_pwdata;
   logic [31:0] model_hrdata;

   ahb2apb_bridge_nslv #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(NS), .SLOT_BITS(8), .TIMEOUT_CYCLES(TO)
   ) dut (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HTRANS(HTRANS), .HWRITE(HWRITE),
      .HADDR(HADDR), .HWDATA(HWDATA), .HREADYIN(HREADYIN), .HREADYOUT(HREADYOUT),
      .HRDATA(HRDATA), .HRESP(HRESP), .PSEL(PSEL), .PADDR(PADDR), .PWRITE(PWRITE),
      .PENABLE(PENABLE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   always #5 HCLK = ~HCLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_psel"},    32'(PSEL),    32'd0);
      check({tag, "_penable"}, 32'(PENABLE), 32'd0);
      check({tag, "_pwrite"},  32'(PWRITE),  32'd0);
      check({tag, "_paddr"},   PADDR,        32'd0);
      check({tag, "_pwdata"},  PWDATA,       32'd0);
      check({tag, "_hrdata"},  HRDATA,       32'd0);
      check({tag, "_hready"},  32'(HREADYOUT), 32'd1);
      check({tag, "_hresp"},   32'(HRESP),   32'd0);
   endtask

   // Idle or BUSY cycles with random HSEL: bridge must answer ready/OKAY with no APB activity
   task automatic idle(input int n);
      logic [31:0] r;
      for (int i = 0; i < n; i++) begin
         r = $urandom;
         HSEL   = r[0];
         HTRANS = {1'b0, r[1]};
         HADDR  = $urandom;
         @(negedge HCLK);
         check("idle_hready", 32'(HREADYOUT), 32'd1);
         check("idle_hresp",  32'(HRESP),     32'd0);
         check("idle_psel",   32'(PSEL),      32'd0);
      end
   endtask

   // One AHB transfer starting now (caller is just after a negedge with the bridge ready)
   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input int waits, input logic [31:0] rdata, input logic err);
      logic        bad, tmo, done, setup_seen, pwrite_seen;
      logic [3:0]  slot;
      logic [NS-1:0] psel_seen, exp_psel;
      logic [31:0] paddr_seen, pwdata_seen, r;
      int lat, en_cyc, resp_cyc, exp_lat, exp_en;
      slot = addr[11:8];
      bad  = (slot >= 4'(NS));
      tmo  = 1'b0;
`ifdef AHB2APB_TIMEOUT_EN
      tmo  = !bad && (waits >= TO);
`endif
      exp_psel = bad ? {NS{1'b0}} : (NS'(1) << slot);
      lat = 0; en_cyc = 0; resp_cyc = 0; done = 1'b0; setup_seen = 1'b0;
      psel_seen = '0; paddr_seen = 32'd0; pwdata_seen = 32'd0; pwrite_seen = 1'b0;
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = addr;
      while (!done) begin
         @(negedge HCLK);
         lat++;
         if (lat == 1) begin
            HSEL = 1'b0; HTRANS = 2'b10; HWDATA = wdata;
            r = $urandom; HWRITE = r[0]; HADDR = $urandom;
         end
         check("psel_onehot0", 32'($onehot0(PSEL)), 32'd1);
         if (HRESP) resp_cyc++;
         if (PSEL != '0 && !PENABLE && !setup_seen) begin
            setup_seen = 1'b1; psel_seen = PSEL; paddr_seen = PADDR;
            pwrite_seen = PWRITE; pwdata_seen = PWDATA;
         end
         r = $urandom;
         if (PSEL != '0 && PENABLE) begin
            if (en_cyc == waits) begin
               PREADY = 1'b1; PRDATA = rdata; PSLVERR = err;
            end else begin
               PREADY = 1'b0; PRDATA = $urandom; PSLVERR = r[1];
            end
            en_cyc++;
         end else begin
            PREADY = r[0]; PRDATA = $urandom; PSLVERR = r[1];
         end
         if (HREADYOUT) done = 1'b1;
         else if (lat >= 400) begin
            check("xfer_timeout_bound", 32'(lat), 32'd0);
            done = 1'b1;
         end
      end
      PREADY = 1'b0; PSLVERR = 1'b0;
      exp_lat = bad ? 2 : (tmo ? 4 + TO : (err ? 5 + waits : 4 + waits));
      exp_en  = bad ? 0 : (tmo ? TO : waits + 1);
      check("latency",       32'(lat),      32'(exp_lat));
      check("enable_cycles", 32'(en_cyc),   32'(exp_en));
      check("error_cycles",  32'(resp_cyc), (bad || err || tmo) ? 32'd2 : 32'd0);
      check("final_hresp",   32'(HRESP),    32'(bad || err || tmo));
      check("setup_seen",    32'(setup_seen), 32'(!bad));
      if (!bad) begin
         if (wr) model_pwdata = wdata;
         check("psel",   32'(psel_seen),   32'(exp_psel));
         check("paddr",  paddr_seen,       addr);
         check("pwrite", 32'(pwrite_seen), 32'(wr));
         check("pwdata", pwdata_seen,      model_pwdata);
         if (!wr && !err && !tmo) model_hrdata = rdata;
      end
      check("hrdata", HRDATA, model_hrdata);
   endtask

   // Drive an address phase and run until the bridge sits in ACCESS with PREADY low
   task automatic start_access(input logic wr, input logic [31:0] addr);
      logic ok;
      ok = 1'b0;
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = addr; PREADY = 1'b0;
      for (int i = 0; i < 8 && !ok; i++) begin
         @(negedge HCLK);
         if (i == 0) begin
            HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'hDEAD_BEEF;
         end
         PREADY = 1'b0;
         if (PENABLE) ok = 1'b1;
      end
      check("access_reached", 32'(ok), 32'd1);
   endtask

   initial begin
      logic [31:0] r, a;
      HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'd0;
      HWDATA = 32'd0; HREADYIN = 1'b1; PRDATA = 32'd0; PREADY = 1'b0; PSLVERR = 1'b0;
      model_pwdata = 32'd0; model_hrdata = 32'd0;
      repeat (2) @(negedge HCLK);
      check_reset_values("reset");
      HRESET = 1'b0;
      idle(3);

      // Directed: zero-wait write, waited read, slave error, back-to-back from ERR2, unmapped slot
      xfer(1'b1, 32'h0000_0304, 32'hA5A5_0001, 0, 32'd0, 1'b0);
      idle(1);
      xfer(1'b0, 32'h0000_0010, 32'h0000_0000, 3, 32'h1234_5678, 1'b0);
      idle(1);
      xfer(1'b0, 32'h0000_0120, 32'h0000_0000, 1, 32'hCAFE_F00D, 1'b1);
      xfer(1'b1, 32'h0000_0200, 32'h5A5A_1234, 0, 32'd0, 1'b0);
      idle(1);
      xfer(1'b1, 32'h0000_0500, 32'h1111_2222, 0, 32'd0, 1'b0);
      xfer(1'b0, 32'h0000_0F00, 32'h0000_0000, 0, 32'h3333_4444, 1'b0);
      idle(2);

      // Random transfers, some to unmapped slots, some with waits or slave error
      for (int k = 0; k < 24; k++) begin
         r = $urandom;
         a = $urandom;
         a[11:8] = 4'($urandom_range(0, 5));
         xfer(r[0], a, $urandom, int'($urandom_range(0, 3)), $urandom, (r[3:2] == 2'b11));
         idle(int'(r[5:4]) % 3);
      end

`ifdef AHB2APB_TIMEOUT_EN
      xfer(1'b0, 32'h0000_0110, 32'h0000_0000, 1000, 32'h7777_7777, 1'b0);
      idle(1);
      start_access(1'b1, 32'h0000_0208);
`else
      start_access(1'b1, 32'h0000_0208);
      repeat (40) @(negedge HCLK);
      check("stuck_penable", 32'(PENABLE),   32'd1);
      check("stuck_psel",    32'(PSEL),      32'h4);
      check("stuck_hready",  32'(HREADYOUT), 32'd0);
`endif

      // Reset mid-ACCESS with a NONSEQ presented during reset, then a normal write
      HRESET = 1'b1; HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0000_0100;
      @(negedge HCLK);
      check_reset_values("midreset");
      HRESET = 1'b0; HSEL = 1'b0; HTRANS = 2'b00;
      model_pwdata = 32'd0; model_hrdata = 32'd0;
      @(negedge HCLK);
      check("post_reset_hready", 32'(HREADYOUT), 32'd1);
      check("post_reset_psel",   32'(PSEL),      32'd0);
      xfer(1'b1, 32'h0000_0304, 32'hA5A5_0001, 0, 32'd0, 1'b0);
      xfer(1'b0, 32'h0000_0304, 32'h0000_0000, 2, 32'h0BAD_CAFE, 1'b0);
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
